keypad_operand_entry: RTL and testbench

KEYPAD_OPERAND_ENTRY -- requirements
Module: keypad_operand_entry

---
 rtl/keypad_operand_entry.sv | 215 +++++++++++++++++++++
 tb/tb_keypad_operand_entry.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_operand_entry.sv
// Scans a 4x4 keypad, debounces single key presses and collects three hex keys
// into an {a, b, sel} operand set that is handed to an ALU with a valid/ack pair.
module keypad_operand_entry #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] sel,
  output logic       op_valid,
  input  logic       op_ack,
  output logic [1:0] entry_state
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE);

  typedef enum logic [1:0] {
    DB_IDLE, DB_PRESS_WAIT, DB_HELD, DB_RELEASE_WAIT
  } db_state_t;

  typedef enum logic [1:0] {
    GET_A = 2'b00, GET_B = 2'b01, GET_SEL = 2'b10, PENDING = 2'b11
  } entry_state_t;

  logic [SW-1:0] scan_cnt;
  logic [1:0]    col_idx;
  logic          slot_end;
  logic          frame_end;

  assign slot_end  = (scan_cnt == SCAN_LAST);
  assign frame_end = slot_end && (col_idx == 2'd3);
  assign col_n     = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      col_idx  <= 2'd0;
    end else if (slot_end) begin
      scan_cnt <= '0;
      col_idx  <= col_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Per-frame hit counting: acc_hits saturates at 2, which already means "invalid".
  logic [3:0] row_low;
  logic [2:0] row_hits;
  logic [1:0] row_idx;
  logic [1:0] acc_hits;
  logic [3:0] acc_key;
  logic [2:0] hit_sum;
  logic [1:0] frame_hits;
  logic [3:0] frame_key;
  logic       frame_none;
  logic       frame_single;

  always_comb begin
    row_low  = ~row_n;
    row_hits = 3'd0;
    row_idx  = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (row_low[r]) begin
        row_hits = row_hits + 3'd1;
        row_idx  = 2'(r);
      end
    end
    hit_sum    = 3'(acc_hits) + row_hits;
    frame_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    frame_key  = (acc_hits == 2'd0) ? {row_idx, col_idx} : acc_key;
  end

  assign frame_none   = frame_end && (frame_hits == 2'd0);
  assign frame_single = frame_end && (frame_hits == 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hits <= 2'd0;
      acc_key  <= 4'd0;
    end else if (slot_end) begin
      if (col_idx == 2'd3) begin
        acc_hits <= 2'd0;
        acc_key  <= 4'd0;
      end else begin
        acc_hits <= frame_hits;
        acc_key  <= frame_key;
      end
    end
  end

  db_state_t     db_state, db_next;
  logic [DW-1:0] db_count, count_next, count_inc;
  logic [3:0]    cand_key, cand_next;
  logic          accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_state <= DB_IDLE;
      db_count <= '0;
      cand_key <= 4'd0;
    end else begin
      db_state <= db_next;
      db_count <= count_next;
      cand_key <= cand_next;
    end
  end

  assign count_inc = (db_count == DB_MAX) ? DB_MAX : db_count + DW'(1);

  always_comb begin
    db_next    = db_state;
    count_next = db_count;
    cand_next  = cand_key;
    if (frame_end) begin
      case (db_state)
        DB_IDLE: begin
          if (frame_single) begin
            cand_next  = frame_key;
            count_next = DW'(1);
            db_next    = (DEBOUNCE <= 1) ? DB_HELD : DB_PRESS_WAIT;
          end
        end
        DB_PRESS_WAIT: begin
          if (frame_single && (frame_key == cand_key)) begin
            count_next = count_inc;
            if (count_inc == DB_MAX) db_next = DB_HELD;
          end else begin
            count_next = '0;
            db_next    = DB_IDLE;
          end
        end
        DB_HELD: begin
          if (frame_none) begin
            count_next = DW'(1);
            db_next    = (DEBOUNCE <= 1) ? DB_IDLE : DB_RELEASE_WAIT;
          end
        end
        DB_RELEASE_WAIT: begin
          if (frame_none) begin
            count_next = count_inc;
            if (count_inc == DB_MAX) begin
              count_next = '0;
              db_next    = DB_IDLE;
            end
          end else begin
            count_next = '0;
            db_next    = DB_HELD;
          end
        end
        default: db_next = DB_IDLE;
      endcase
    end
  end

  // Only the step into HELD accepts a key, so a held key strobes once.
  always_comb begin
    accept = (db_next == DB_HELD) &&
             ((db_state == DB_IDLE) || (db_state == DB_PRESS_WAIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_strobe <= 1'b0;
      key_code   <= 4'd0;
    end else begin
      key_strobe <= accept;
      if (accept) key_code <= frame_key;
    end
  end

  entry_state_t entry, entry_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) entry <= GET_A;
    else        entry <= entry_next;
  end

  always_comb begin
    entry_next = entry;
    case (entry)
      GET_A:   if (key_strobe) entry_next = GET_B;
      GET_B:   if (key_strobe) entry_next = GET_SEL;
      GET_SEL: if (key_strobe) entry_next = PENDING;
      PENDING: if (op_ack)     entry_next = GET_A;
      default: entry_next = GET_A;
    endcase
  end

  always_comb begin
    entry_state = entry;
    op_valid    = (entry == PENDING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a   <= 4'd0;
      b   <= 4'd0;
      sel <= 4'd0;
    end else if (key_strobe) begin
      if (entry == GET_A)   a   <= key_code;
      if (entry == GET_B)   b   <= key_code;
      if (entry == GET_SEL) sel <= key_code;
    end
  end

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Bench for keypad_operand_entry: a keypad model drives row_n from a pressed-key mask,
// accepted keys are scoreboarded and the operand registers are checked per step.
module tb_keypad_operand_entry;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_n, row_n, key_code, a, b, sel;
  logic       key_strobe, op_valid;
  logic       op_ack = 1'b0;
  logic [1:0] entry_state;

  logic [15:0] pressed = 16'h0000;
  logic [3:0]  col_prev;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_key;
  logic [3:0]  last_key = 4'h0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [15:0] keys;
    int          frames;
    bit          strobe;
    logic [3:0]  key;
    logic [3:0]  ea, eb, esel;
    logic        evalid;
    logic [1:0]  estate;
  } step_t;

  step_t steps[26];

  always #5 clk = ~clk;

  keypad_operand_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n),
    .key_code(key_code), .key_strobe(key_strobe), .a(a), .b(b), .sel(sel),
    .op_valid(op_valid), .op_ack(op_ack), .entry_state(entry_state)
  );

  // Key K = row*4 + col pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(posedge clk) col_prev <= col_n;

  always @(negedge clk) begin
    if (rst_n && key_strobe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_strobe: got key %0h, expected no strobe", key_code);
      end else begin
        exp_key = exp_q.pop_front();
        if (key_code !== exp_key) begin
          errors++;
          $display("[TB] FAIL strobe_key: got %0h, expected %0h", key_code, exp_key);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic align();
    int n = 0;
    while (!(col_n === 4'b1110 && col_prev === 4'b0111) && n < 2*FRAME) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2*FRAME) begin
      checks++;
      errors++;
      $display("[TB] FAIL align_timeout: got no frame start in %0d cycles, expected one", n);
    end
  endtask

  task automatic applyStimulus(input int idx);
    step_t s = steps[idx];
    align();
    pressed = s.keys;
    if (s.strobe) begin
      exp_q.push_back(s.key);
      last_key = s.key;
    end
    repeat (s.frames * FRAME) @(posedge clk);
    #1;
    checkOutput($sformatf("step%0d_missing_strobes", idx), exp_q.size(), 0);
    exp_q.delete();
    checkOutput($sformatf("step%0d_key_code", idx), key_code, last_key);
    checkOutput($sformatf("step%0d_a", idx), a, s.ea);
    checkOutput($sformatf("step%0d_b", idx), b, s.eb);
    checkOutput($sformatf("step%0d_sel", idx), sel, s.esel);
    checkOutput($sformatf("step%0d_op_valid", idx), op_valid, s.evalid);
    checkOutput($sformatf("step%0d_entry_state", idx), entry_state, s.estate);
  endtask

  task automatic runSteps(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) applyStimulus(i);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    //             keys      fr str key  a     b     sel   vld   state
    steps[0]  = '{16'h0040, 3, 1, 4'h6, 4'h6, 4'h0, 4'h0, 1'b0, 2'd1};
    steps[1]  = '{16'h0000, 3, 0, 4'h0, 4'h6, 4'h0, 4'h0, 1'b0, 2'd1};
    steps[2]  = '{16'h0400, 3, 1, 4'hA, 4'h6, 4'hA, 4'h0, 1'b0, 2'd2};
    steps[3]  = '{16'h0000, 3, 0, 4'h0, 4'h6, 4'hA, 4'h0, 1'b0, 2'd2};
    steps[4]  = '{16'h8000, 3, 1, 4'hF, 4'h6, 4'hA, 4'hF, 1'b1, 2'd3};
    steps[5]  = '{16'h0000, 3, 0, 4'h0, 4'h6, 4'hA, 4'hF, 1'b1, 2'd3};
    steps[6]  = '{16'h0008, 3, 1, 4'h3, 4'h6, 4'hA, 4'hF, 1'b1, 2'd3};
    steps[7]  = '{16'h0000, 3, 0, 4'h0, 4'h6, 4'hA, 4'hF, 1'b1, 2'd3};
    steps[8]  = '{16'h0004, 3, 1, 4'h2, 4'h2, 4'hA, 4'hF, 1'b0, 2'd1};
    steps[9]  = '{16'h0000, 3, 0, 4'h0, 4'h2, 4'hA, 4'hF, 1'b0, 2'd1};
    steps[10] = '{16'h0022, 5, 0, 4'h0, 4'h2, 4'hA, 4'hF, 1'b0, 2'd1};
    steps[11] = '{16'h0000, 3, 0, 4'h0, 4'h2, 4'hA, 4'hF, 1'b0, 2'd1};
    steps[12] = '{16'h0200, 1, 0, 4'h0, 4'h2, 4'hA, 4'hF, 1'b0, 2'd1};
    steps[13] = '{16'h0000, 3, 0, 4'h0, 4'h2, 4'hA, 4'hF, 1'b0, 2'd1};
    steps[14] = '{16'h0080, 3, 1, 4'h7, 4'h2, 4'h7, 4'hF, 1'b0, 2'd2};
    steps[15] = '{16'h0000, 3, 0, 4'h0, 4'h2, 4'h7, 4'hF, 1'b0, 2'd2};
    steps[16] = '{16'h0100, 3, 1, 4'h8, 4'h2, 4'h7, 4'h8, 1'b1, 2'd3};
    steps[17] = '{16'h0000, 3, 0, 4'h0, 4'h2, 4'h7, 4'h8, 1'b1, 2'd3};
    steps[18] = '{16'h0000, 3, 0, 4'h0, 4'h2, 4'h7, 4'h8, 1'b0, 2'd0};
    steps[19] = '{16'h0010, 3, 1, 4'h4, 4'h4, 4'h7, 4'h8, 1'b0, 2'd1};
    steps[20] = '{16'h0000, 3, 0, 4'h0, 4'h4, 4'h7, 4'h8, 1'b0, 2'd1};
    steps[21] = '{16'h0020, 3, 1, 4'h5, 4'h4, 4'h5, 4'h8, 1'b0, 2'd2};
    steps[22] = '{16'h0000, 3, 0, 4'h0, 4'h4, 4'h5, 4'h8, 1'b0, 2'd2};
    steps[23] = '{16'h0040, 3, 1, 4'h6, 4'h4, 4'h5, 4'h6, 1'b1, 2'd3};
    steps[24] = '{16'h0000, 3, 0, 4'h0, 4'h4, 4'h5, 4'h6, 1'b1, 2'd3};
    steps[25] = '{16'h0200, 3, 1, 4'h9, 4'h9, 4'h0, 4'h0, 1'b0, 2'd1};

    // Reset values while rst_n is held low, then the column rotation.
    #1;
    checkOutput("reset_col_n", col_n, 4'b1110);
    checkOutput("reset_outputs", {key_code, key_strobe, a, b, sel, op_valid, entry_state},
                {4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      case ((k / 4) % 4)
        0: checkOutput($sformatf("scan_col_%0d", k), col_n, 4'b1110);
        1: checkOutput($sformatf("scan_col_%0d", k), col_n, 4'b1101);
        2: checkOutput($sformatf("scan_col_%0d", k), col_n, 4'b1011);
        default: checkOutput($sformatf("scan_col_%0d", k), col_n, 4'b0111);
      endcase
    end
    checkOutput("idle_outputs", {key_code, key_strobe, a, b, sel, op_valid, entry_state},
                {4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0});

    runSteps(0, 7);

    // Ack in PENDING releases the set on the next cycle.
    checkOutput("pending_valid_before_ack", op_valid, 1'b1);
    op_ack = 1'b1;
    @(posedge clk); #1;
    op_ack = 1'b0;
    checkOutput("ack_op_valid", op_valid, 1'b0);
    checkOutput("ack_entry_state", entry_state, 2'd0);
    checkOutput("ack_retains_abs", {a, b, sel}, {4'h6, 4'hA, 4'hF});

    runSteps(8, 13);

    // Ack outside PENDING has no effect.
    op_ack = 1'b1;
    @(posedge clk); #1;
    op_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stray_ack_state", entry_state, 2'd1);
    checkOutput("stray_ack_valid", op_valid, 1'b0);

    runSteps(14, 17);

    // Ack coincides with the strobe of key E: ack wins, E is not loaded.
    align();
    pressed = 16'h4000;
    exp_q.push_back(4'hE);
    last_key = 4'hE;
    repeat (2 * FRAME) @(posedge clk);
    #1;
    checkOutput("collide_strobe", key_strobe, 1'b1);
    checkOutput("collide_valid", op_valid, 1'b1);
    op_ack = 1'b1;
    @(posedge clk); #1;
    op_ack = 1'b0;
    checkOutput("collide_state", entry_state, 2'd0);
    checkOutput("collide_op_valid", op_valid, 1'b0);
    checkOutput("collide_a", a, 4'h2);

    runSteps(18, 24);

    // Reset during PENDING clears everything immediately.
    rst_n = 1'b0;
    #1;
    last_key = 4'h0;
    checkOutput("pending_reset_valid", op_valid, 1'b0);
    checkOutput("pending_reset_abs", {a, b, sel}, 12'h000);
    checkOutput("pending_reset_col_n", col_n, 4'b1110);
    checkOutput("pending_reset_state", {entry_state, key_code}, 6'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of debouncing key 9 leaves nothing behind.
    align();
    pressed = 16'h0200;
    repeat (FRAME + FRAME / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    pressed = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4 * FRAME) @(posedge clk);
    #1;
    checkOutput("midreset_key_code", key_code, 4'h0);
    checkOutput("midreset_state", {op_valid, entry_state}, 3'b000);

    runSteps(25, 25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
